// File: rtl/gemm_c_tile_writeback.sv
// gemm_c_tile_writeback
// ---------------------------------------------------------------------------
// Takes packed M x N output tiles of 32-bit accumulators from the GEMM
// accelerator, buffers them in a small FIFO and streams them out one element
// per cycle, row-major within the tile, to a row-major C result memory.
//
// Optional feature macro: GEMM_WB_BOUNDS_CHECK_EN
//   defined   : elements outside M_size x N_size still take their cycle but
//               are issued with mem_we_o = 0 (edge tiles of ragged matrices).
//   undefined : every element is written; sizes must be tile multiples.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                latch M_size_i / N_size_i and begin a job (IDLE only)
//   M_size_i, N_size_i     matrix dimensions in elements
//   tile_valid_i/_ready_o  tile handshake (ready never depends on valid)
//   tile_m_i, tile_n_i     tile row / column index
//   tile_last_i            marks the final tile of the job
//   tile_data_i            element (i,j) at bits [(i*N+j)*32 +: 32]
//   mem_addr_o/_wdata_o/_we_o  registered element write port
//   busy_o                 job in progress
//   done_o                 one-cycle pulse after the final write
// ---------------------------------------------------------------------------
module gemm_c_tile_writeback #(
  parameter int M             = 4,
  parameter int N             = 4,
  parameter int AddrWidth     = 10,
  parameter int SizeAddrWidth = 8,
  parameter int FifoDepth     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     tile_valid_i,
  output logic                     tile_ready_o,
  input  logic [SizeAddrWidth-1:0] tile_m_i,
  input  logic [SizeAddrWidth-1:0] tile_n_i,
  input  logic                     tile_last_i,
  input  logic [32*M*N-1:0]        tile_data_i,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic                     mem_we_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int TileW = 32 * M * N;
  localparam int RowW  = (M > 1) ? $clog2(M) : 1;
  localparam int ColW  = (N > 1) ? $clog2(N) : 1;
  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam int BitW  = $clog2(TileW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                     last;
    logic [SizeAddrWidth-1:0] tile_m;
    logic [SizeAddrWidth-1:0] tile_n;
    logic [TileW-1:0]         data;
  } entry_t;

  state_e                   state_q, state_d;
  logic [SizeAddrWidth-1:0] m_size_q, m_size_d;
  logic [SizeAddrWidth-1:0] n_size_q, n_size_d;
  logic                     last_accepted_q, last_accepted_d;
  logic                     final_issued_q, final_issued_d;
  entry_t                   fifo_q [FifoDepth];
  entry_t                   fifo_d [FifoDepth];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [RowW-1:0]          row_q, row_d;
  logic [ColW-1:0]          col_q, col_d;
  logic [AddrWidth-1:0]     mem_addr_q, mem_addr_d;
  logic [31:0]              mem_wdata_q, mem_wdata_d;
  logic                     mem_we_q, mem_we_d;

  entry_t                   head;
  logic                     push;
  logic                     pop;
  logic                     in_range;
  logic [AddrWidth-1:0]     row_addr;
  logic [AddrWidth-1:0]     elem_addr;
  logic [BitW-1:0]          bit_off;

  assign tile_ready_o = (state_q == ST_BUSY) && (count_q < CntW'(FifoDepth)) && !last_accepted_q;
  assign busy_o       = (state_q == ST_BUSY);
  assign done_o       = (state_q == ST_DONE);
  assign push         = tile_valid_i && tile_ready_o;

  assign head = fifo_q[rd_ptr_q];

  // Address arithmetic is done directly in AddrWidth bits: truncating after
  // every multiply/add gives the same result as full precision then wrap.
  assign row_addr  = AddrWidth'(head.tile_m) * AddrWidth'(M) + AddrWidth'(row_q);
  assign elem_addr = row_addr * AddrWidth'(n_size_q)
                   + AddrWidth'(head.tile_n) * AddrWidth'(N) + AddrWidth'(col_q);
  assign bit_off   = BitW'(row_q) * BitW'(N * 32) + BitW'(col_q) * BitW'(32);

`ifdef GEMM_WB_BOUNDS_CHECK_EN
  // Range test needs true row/column indices, so it uses widths that cannot wrap.
  localparam int RowFullW = SizeAddrWidth + RowW + 1;
  localparam int ColFullW = SizeAddrWidth + ColW + 1;
  logic [RowFullW-1:0] row_full;
  logic [ColFullW-1:0] col_full;
  assign row_full = RowFullW'(head.tile_m) * RowFullW'(M) + RowFullW'(row_q);
  assign col_full = ColFullW'(head.tile_n) * ColFullW'(N) + ColFullW'(col_q);
  assign in_range = (row_full < RowFullW'(m_size_q)) && (col_full < ColFullW'(n_size_q));
`else
  // Without bounds checking the row count is only latched, never consulted.
  logic unused_m_size;
  assign unused_m_size = ^m_size_q;
  assign in_range      = 1'b1;
`endif

  // Next-state logic: job FSM, FIFO push/pop and the element drain walk.
  // The head tile is walked i-outer/j-inner; it pops on its final element so
  // the next tile's first element follows on the very next cycle.
  always_comb begin
    state_d         = state_q;
    m_size_d        = m_size_q;
    n_size_d        = n_size_q;
    last_accepted_d = last_accepted_q;
    final_issued_d  = 1'b0;
    fifo_d          = fifo_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    row_d           = row_q;
    col_d           = col_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_we_d        = 1'b0;
    pop             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d         = ST_BUSY;
          m_size_d        = M_size_i;
          n_size_d        = N_size_i;
          last_accepted_d = 1'b0;
        end
      end
      // final_issued_q is one cycle late on purpose: the last write is
      // visible first, then DONE follows in the next cycle.
      ST_BUSY: begin
        if (final_issued_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (count_q != '0) begin
      mem_we_d    = in_range;
      mem_addr_d  = elem_addr;
      mem_wdata_d = head.data[bit_off +: 32];
      if (col_q == ColW'(N - 1)) begin
        col_d = '0;
        if (row_q == RowW'(M - 1)) begin
          row_d          = '0;
          pop            = 1'b1;
          final_issued_d = head.last;
        end else begin
          row_d = row_q + RowW'(1);
        end
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q].last   = tile_last_i;
      fifo_d[wr_ptr_q].tile_m = tile_m_i;
      fifo_d[wr_ptr_q].tile_n = tile_n_i;
      fifo_d[wr_ptr_q].data   = tile_data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (tile_last_i) begin
        last_accepted_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // State registers; reset flushes the FIFO and abandons any drain in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      m_size_q        <= '0;
      n_size_q        <= '0;
      last_accepted_q <= 1'b0;
      final_issued_q  <= 1'b0;
      fifo_q          <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      row_q           <= '0;
      col_q           <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      m_size_q        <= m_size_d;
      n_size_q        <= n_size_d;
      last_accepted_q <= last_accepted_d;
      final_issued_q  <= final_issued_d;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      row_q           <= row_d;
      col_q           <= col_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= mem_we_d;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_gemm_c_tile_writeback.sv
// tb_gemm_c_tile_writeback
// Self-checking bench for gemm_c_tile_writeback. A behavioural model keeps the
// expected element stream as a queue and derives FIFO occupancy from it; one
// negedge process compares every output against it each cycle. Directed
// scenarios add literal expectations; a randomized phase runs several jobs.
`timescale 1ns/1ps
module tb_gemm_c_tile_writeback;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int SW = 8;
  localparam int FD = 2;
  localparam int TW = 32 * M * N;
  localparam int NE = M * N;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b1;
  logic          start      = 1'b0;
  logic [SW-1:0] m_size     = '0;
  logic [SW-1:0] n_size     = '0;
  logic          tile_valid = 1'b0;
  logic [SW-1:0] tile_m     = '0;
  logic [SW-1:0] tile_n     = '0;
  logic          tile_last  = 1'b0;
  logic [TW-1:0] tile_data  = '0;
  logic          tile_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          done;

  gemm_c_tile_writeback #(
    .M(M), .N(N), .AddrWidth(AW), .SizeAddrWidth(SW), .FifoDepth(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .M_size_i(m_size), .N_size_i(n_size),
    .tile_valid_i(tile_valid), .tile_ready_o(tile_ready),
    .tile_m_i(tile_m), .tile_n_i(tile_n), .tile_last_i(tile_last),
    .tile_data_i(tile_data),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int done_cyc = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          we;
    logic          fin;
  } elem_t;

  typedef enum {P_IDLE, P_BUSY, P_DONE} phase_t;

  elem_t         exp_q[$];
  phase_t        ph          = P_IDLE;
  int            ms_lat      = 0;
  int            ns_lat      = 0;
  bit            last_acc    = 0;
  bit            fin_emitted = 0;
  bit            exp_we      = 0;
  bit            exp_ready   = 0;
  logic [AW-1:0] exp_addr    = '0;
  logic [31:0]   exp_data    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      ph = P_IDLE; ms_lat = 0; ns_lat = 0; last_acc = 0; fin_emitted = 0;
      exp_we = 0; exp_ready = 0; exp_addr = '0; exp_data = '0;
    end else begin
      bit    accept;
      elem_t e;
      accept = tile_valid && exp_ready;
      case (ph)
        P_IDLE: if (start) begin ph = P_BUSY; ms_lat = int'(m_size); ns_lat = int'(n_size); last_acc = 0; end
        P_BUSY: if (fin_emitted) ph = P_DONE;
        default: ph = P_IDLE;
      endcase
      fin_emitted = 0;
      exp_we = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_we = e.we; exp_addr = e.addr; exp_data = e.data; fin_emitted = e.fin;
      end
      if (accept) begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < N; j++) begin
            longint row, col, full;
            row = longint'(tile_m) * M + i;
            col = longint'(tile_n) * N + j;
            full = row * ns_lat + col;
            e.addr = full[AW-1:0];
            e.data = tile_data[(i*N+j)*32 +: 32];
`ifdef GEMM_WB_BOUNDS_CHECK_EN
            e.we = (row < ms_lat) && (col < ns_lat);
`else
            e.we = 1'b1;
`endif
            e.fin = tile_last && (i == M-1) && (j == N-1);
            exp_q.push_back(e);
          end
        end
        if (tile_last) last_acc = 1;
      end
      exp_ready = (ph == P_BUSY) && (((exp_q.size() + NE - 1) / NE) < FD) && !last_acc;
    end
  end

  // ---------------- compare process + write log ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t wr_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("mem_we", 64'(mem_we), 64'(exp_we));
      if (exp_we) begin
        checkOutput("mem_addr", 64'(mem_addr), 64'(exp_addr));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(exp_data));
      end
      checkOutput("tile_ready", 64'(tile_ready), 64'(exp_ready));
      checkOutput("busy", 64'(busy), 64'(ph == P_BUSY));
      checkOutput("done", 64'(done), 64'(ph == P_DONE));
      if (mem_we) wr_log.push_back('{cycle, mem_addr, mem_wdata});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input int ms, input int ns);
    start = 1'b1; m_size = SW'(ms); n_size = SW'(ns);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [SW-1:0] tm, input logic [SW-1:0] tn,
                               input logic last, input logic [TW-1:0] data, output int acc_cyc);
    bit taken = 0;
    acc_cyc = -1;
    tile_valid = 1'b1; tile_m = tm; tile_n = tn; tile_last = last; tile_data = data;
    for (int k = 0; k < 300 && !taken; k++) begin
      @(negedge clk);
      if (tile_ready) begin taken = 1; acc_cyc = cycle; end
      @(posedge clk); #1;
    end
    tile_valid = 1'b0; tile_last = 1'b0;
    if (!taken) begin
      checks++; failures++;
      $display("[TB] FAIL tile_accept: got no handshake in 300 cycles, expected one");
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; done_cyc = cycle; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("[TB] FAIL done_timeout: got no done_o in 400 cycles, expected a pulse");
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [TW-1:0] marked_tile(input logic [31:0] base);
    logic [TW-1:0] d;
    for (int k = 0; k < NE; k++) d[k*32 +: 32] = base | 32'(k);
    return d;
  endfunction

  function automatic int find_data(input logic [31:0] d);
    for (int k = 0; k < wr_log.size(); k++) if (wr_log[k].data == d) return k;
    return -1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    checkOutput({tag, "_tile_ready"}, 64'(tile_ready), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int a0, a1, a2, idx;
    logic [TW-1:0] d;

    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single tile, 4x4 matrix
    start_job(4, 4);
    wr_log.delete();
    for (int k = 0; k < NE; k++) d[k*32 +: 32] = 32'(k + 1);
    applyStimulus(0, 0, 1'b1, d, a0);
    wait_done();
    checkOutput("t1_write_count", 64'(wr_log.size()), 64'd16);
    if (wr_log.size() == 16) begin
      checkOutput("t1_first_latency", 64'(wr_log[0].cyc), 64'(a0 + 2));
      for (int k = 0; k < 16; k++) begin
        checkOutput("t1_addr", 64'(wr_log[k].addr), 64'(k));
        checkOutput("t1_data", 64'(wr_log[k].data), 64'(k + 1));
        checkOutput("t1_consecutive", 64'(wr_log[k].cyc), 64'(wr_log[0].cyc + k));
      end
      checkOutput("t1_done_cycle", 64'(done_cyc), 64'(wr_log[15].cyc + 1));
    end

    // multi-tile addressing, 8x8 matrix
    start_job(8, 8);
    wr_log.delete();
    applyStimulus(1, 0, 1'b0, marked_tile(32'hA000_0000), a0);
    applyStimulus(0, 1, 1'b1, marked_tile(32'hB000_0000), a1);
    wait_done();
    idx = find_data(32'hA000_000B);
    checkOutput("t2_found_1_0_e23", 64'(idx >= 0), 64'd1);
    if (idx >= 0) checkOutput("t2_addr_51", 64'(wr_log[idx].addr), 64'd51);
    idx = find_data(32'hB000_0000);
    checkOutput("t2_found_0_1_e00", 64'(idx >= 0), 64'd1);
    if (idx >= 0) checkOutput("t2_addr_4", 64'(wr_log[idx].addr), 64'd4);

`ifdef GEMM_WB_BOUNDS_CHECK_EN
    // edge tile on a 5x6 matrix
    start_job(5, 6);
    wr_log.delete();
    applyStimulus(1, 1, 1'b1, marked_tile(32'hE000_0000), a0);
    wait_done();
    checkOutput("t3_write_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      checkOutput("t3_addr0", 64'(wr_log[0].addr), 64'd28);
      checkOutput("t3_addr1", 64'(wr_log[1].addr), 64'd29);
      checkOutput("t3_data1", 64'(wr_log[1].data), 64'hE000_0001);
    end
`endif

    // backpressure: three tiles offered back to back
    start_job(8, 8);
    wr_log.delete();
    applyStimulus(0, 0, 1'b0, marked_tile(32'h1000_0000), a0);
    applyStimulus(0, 1, 1'b0, marked_tile(32'h2000_0000), a1);
    applyStimulus(1, 0, 1'b1, marked_tile(32'h3000_0000), a2);
    wait_done();
    checkOutput("t4_second_accept", 64'(a1 - a0), 64'd1);
    checkOutput("t4_third_accept", 64'(a2 - a0), 64'd17);
    checkOutput("t4_write_count", 64'(wr_log.size()), 64'd48);
    if (wr_log.size() == 48) begin
      checkOutput("t4_first_write", 64'(wr_log[0].cyc), 64'(a0 + 2));
      checkOutput("t4_no_gaps", 64'(wr_log[47].cyc - wr_log[0].cyc), 64'd47);
    end

    // start while busy is ignored
    start_job(8, 8);
    wr_log.delete();
    applyStimulus(0, 1, 1'b0, marked_tile(32'hC000_0000), a0);
    start = 1'b1; m_size = 8'd2; n_size = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    applyStimulus(1, 1, 1'b1, marked_tile(32'hD000_0000), a1);
    wait_done();
    idx = find_data(32'hC000_0005);
    checkOutput("t5_found_c11", 64'(idx >= 0), 64'd1);
    if (idx >= 0) checkOutput("t5_addr_13", 64'(wr_log[idx].addr), 64'd13);
    idx = find_data(32'hD000_0000);
    checkOutput("t5_found_d00", 64'(idx >= 0), 64'd1);
    if (idx >= 0) checkOutput("t5_addr_36", 64'(wr_log[idx].addr), 64'd36);

    // reset at element 7 of a tile
    start_job(8, 8);
    applyStimulus(0, 0, 1'b0, marked_tile(32'h7000_0000), a0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t6_mid_drain_we", 64'(mem_we), 64'd1);
    checkOutput("t6_mid_drain_elem7", 64'(mem_wdata), 64'h7000_0007);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("t6_reset");
    @(negedge clk); #1 rst_n = 1'b1;
    wr_log.delete();
    tile_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6_no_residual_writes", 64'(wr_log.size()), 64'd0);
    checkOutput("t6_ready_before_start", 64'(tile_ready), 64'd0);
    tile_valid = 1'b0;

    // randomized jobs
    for (int job = 0; job < 8; job++) begin
      int ms, ns, ntiles;
`ifdef GEMM_WB_BOUNDS_CHECK_EN
      ms = int'($urandom_range(1, 64));
      ns = int'($urandom_range(1, 64));
`else
      ms = 4 * int'($urandom_range(1, 16));
      ns = 4 * int'($urandom_range(1, 16));
`endif
      start_job(ms, ns);
      ntiles = int'($urandom_range(1, 4));
      for (int t = 0; t < ntiles; t++) begin
        for (int k = 0; k < NE; k++) d[k*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; m_size = SW'($urandom_range(1, 64)); n_size = SW'($urandom_range(1, 64));
          @(posedge clk); #1;
          start = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        applyStimulus(SW'($urandom_range(0, (ms - 1) / M)), SW'($urandom_range(0, (ns - 1) / N)),
                      t == ntiles - 1, d, a0);
      end
      wait_done();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
